// File: rtl/l2_responder.sv
// rtl/l2_responder.sv - block-granular L2 memory responder with programmable latency
module l2_responder #(
    parameter int BLOCK_SIZE = 2,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 4,
    localparam int DATA_WIDTH = 32 * BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  l2REN,
    input  logic                  l2WEN,
    input  logic [31:0]           l2addr,
    input  logic [DATA_WIDTH-1:0] l2store,
    output logic [DATA_WIDTH-1:0] l2load,
    output logic [1:0]            l2state,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic [15:0]           err_count
);

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] LAT8 = 8'(LATENCY);

    l2_state_t             state_q;
    logic [7:0]            cnt_q;
    logic                  op_wr_q;
    logic [AW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] load_q;
    logic [31:0]           rd_cnt_q;
    logic [31:0]           wr_cnt_q;
    logic [15:0]           err_cnt_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req;
    logic                  both;
    logic                  legal;
    logic [AW-1:0]         in_idx;
    logic                  op_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign req    = l2REN | l2WEN;
    assign both   = l2REN & l2WEN;
    assign in_idx = l2addr[3 +: AW];
    // Aligned to an 8-byte block and below DEPTH*8: every bit above the index must be zero.
    assign legal  = (l2addr[2:0] == 3'b000) && (l2addr[31:AW+3] == '0);
    // The abort test only watches the enable of the op that was latched.
    assign op_en  = op_wr_q ? l2WEN : l2REN;

    // Memory write strobe: fires only on the edge that enters ACCESS for a write, never while in reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = idx_q;
        mem_wdata = data_q;
        if (nRST) begin
            case (state_q)
                L2_FREE: begin
                    if (LATENCY == 0 && req && !both && legal && l2WEN) begin
                        mem_we    = 1'b1;
                        mem_widx  = in_idx;
                        mem_wdata = l2store;
                    end
                end
                L2_BUSY: begin
                    if (op_en && cnt_q == 8'd1 && op_wr_q) begin
                        mem_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Block store; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Request FSM with registered load data and completion counters.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q   <= L2_FREE;
            cnt_q     <= 8'd0;
            op_wr_q   <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            load_q    <= '0;
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
            err_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                L2_FREE: begin
                    load_q <= '0;
                    if (req) begin
                        if (both || !legal) begin
                            state_q <= L2_ERROR;
                        end else begin
                            op_wr_q <= l2WEN;
                            idx_q   <= in_idx;
                            data_q  <= l2store;
                            if (LATENCY == 0) begin
                                cnt_q   <= 8'd0;
                                state_q <= L2_ACCESS;
                                if (!l2WEN) begin
                                    load_q <= mem[in_idx];
                                end
                            end else begin
                                cnt_q   <= LAT8;
                                state_q <= L2_BUSY;
                            end
                        end
                    end
                end
                L2_BUSY: begin
                    if (!op_en) begin
                        cnt_q   <= 8'd0;
                        state_q <= L2_FREE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q <= L2_ACCESS;
                            if (!op_wr_q) begin
                                load_q <= mem[idx_q];
                            end
                        end
                    end
                end
                L2_ACCESS: begin
                    state_q <= L2_FREE;
                    load_q  <= '0;
                    if (op_wr_q) begin
                        wr_cnt_q <= wr_cnt_q + 32'd1;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= L2_FREE;
                    load_q  <= '0;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign l2state   = state_q;
    assign l2load    = load_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;

endmodule
